// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a registered valid/ready output slot and sticky overrun.
// Define SIPO_DESER_PARITY_CHECK_EN to append an even-parity bit per frame and expose parity_err.
module sipo_deser #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] qout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
`ifdef SIPO_DESER_PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_DESER_PARITY_CHECK_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned    CW        = $clog2(FRAME + 1);
    localparam logic [CW-1:0]  LAST      = CW'(FRAME - 1);
    localparam logic [CW-1:0]  DATA_BITS = CW'(WIDTH);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_eff;
    logic             complete;
    logic             shift_en;
    logic             slot_free;
`ifdef SIPO_DESER_PARITY_CHECK_EN
    logic             word_perr;
`endif

    always_comb begin
        // frame_start makes the current bit position 0 regardless of the stored count
        cnt_eff   = frame_start ? '0 : cnt;
        shifted   = MSB_FIRST ? {sh[WIDTH-2:0], serial_in} : {serial_in, sh[WIDTH-1:1]};
        complete  = bit_valid && (cnt_eff == LAST);
        shift_en  = bit_valid && (cnt_eff < DATA_BITS);
        slot_free = !out_valid || out_ready;
`ifdef SIPO_DESER_PARITY_CHECK_EN
        // parity bit is the last of the frame; data is already fully shifted in
        word      = sh;
        word_perr = (^sh) ^ serial_in;
`else
        word      = shifted;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh         <= '0;
            cnt        <= '0;
            qout       <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_DESER_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (shift_en)
                sh <= shifted;

            if (bit_valid)
                cnt <= complete ? '0 : cnt_eff + CW'(1);
            else if (frame_start)
                cnt <= '0;

            if (complete && slot_free) begin
                qout       <= word;
                out_valid  <= 1'b1;
`ifdef SIPO_DESER_PARITY_CHECK_EN
                parity_err <= word_perr;
`endif
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: MSB-first and LSB-first instances share one random/directed bit stream.
// Also supports builds with SIPO_DESER_PARITY_CHECK_EN defined.
module tb_sipo_deser;

    localparam int WIDTH = 4;
`ifdef SIPO_DESER_PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             serial_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] qout [2];
    logic             out_valid [2];
    logic             overrun [2];
`ifdef SIPO_DESER_PARITY_CHECK_EN
    logic             parity_err [2];
`endif

    always #5 clk = ~clk;

    // lane index equals the MSB_FIRST setting of the instance
    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .qout(qout[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .overrun(overrun[0])
`ifdef SIPO_DESER_PARITY_CHECK_EN
        , .parity_err(parity_err[0])
`endif
    );

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .qout(qout[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .overrun(overrun[1])
`ifdef SIPO_DESER_PARITY_CHECK_EN
        , .parity_err(parity_err[1])
`endif
    );

    typedef struct {
        int               lane;
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    exp_t expq [$];
    logic bits [$];
    logic m_valid = 1'b0;
    logic m_overrun = 1'b0;
    logic done = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: frame = list of received bits, mapped onto word positions
    initial begin
        logic [WIDTH-1:0] w_msb, w_lsb;
        logic             p;
        exp_t             e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                bits.delete();
                expq.delete();
                m_valid   = 1'b0;
                m_overrun = 1'b0;
            end else begin
                if (frame_start)
                    bits.delete();
                if (bit_valid)
                    bits.push_back(serial_in);
                if (bits.size() == FRAME) begin
                    p = 1'b0;
                    for (int k = 0; k < WIDTH; k++) begin
                        w_msb[WIDTH-1-k] = bits[k];
                        w_lsb[k]         = bits[k];
                    end
                    foreach (bits[k]) p ^= bits[k];
                    bits.delete();
                    if (!m_valid || out_ready) begin
                        e.lane = 0; e.word = w_lsb; e.perr = p; expq.push_back(e);
                        e.lane = 1; e.word = w_msb; e.perr = p; expq.push_back(e);
                        m_valid = 1'b1;
                    end else begin
                        m_overrun = 1'b1;
                    end
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s lane%0d: got %0h, expected %0h (t=%0t)", nm, lane, act, exp, $time);
    endtask

    // Monitor: checks flags every cycle and pops the scoreboard once per presented word
    initial begin
        logic seen [2];
        int   idx;
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (done) break;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    check("reset_qout", i, 32'(qout[i]), 32'd0);
`ifdef SIPO_DESER_PARITY_CHECK_EN
                    check("reset_parity_err", i, 32'(parity_err[i]), 32'd0);
`endif
                end
                check("out_valid", i, 32'(out_valid[i]), 32'(m_valid));
                check("overrun", i, 32'(overrun[i]), 32'(m_overrun));
                if (out_valid[i] && !seen[i]) begin
                    idx = -1;
                    foreach (expq[k])
                        if (idx < 0 && expq[k].lane == i) idx = k;
                    if (idx < 0) begin
                        check("unexpected_word", i, 32'(qout[i]), 32'hFFFF_FFFF);
                    end else begin
                        check("qout", i, 32'(qout[i]), 32'(expq[idx].word));
`ifdef SIPO_DESER_PARITY_CHECK_EN
                        check("parity_err", i, 32'(parity_err[i]), 32'(expq[idx].perr));
`endif
                        expq.delete(idx);
                    end
                    seen[i] = 1'b1;
                end
                if (!out_valid[i] || out_ready)
                    seen[i] = 1'b0;
            end
        end
        check("queue_empty", 0, 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic idle(input int n);
        repeat (n) begin
            bit_valid   = 1'b0;
            frame_start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic b, input logic fs);
        serial_in   = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        @(posedge clk); #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Data bits in transmission order w[WIDTH-1] first, plus correct even parity when enabled
    task automatic send_frame(input logic [WIDTH-1:0] w, input int gap);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            send(w[k], 1'b0);
            idle(gap);
        end
`ifdef SIPO_DESER_PARITY_CHECK_EN
        send(^w, 1'b0);
        idle(gap);
`endif
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        out_ready = 1'b1;
        send_frame(4'b1011, 0);
        idle(3);
        send_frame(4'b1011, 3);
        idle(3);

        out_ready = 1'b0;
        send_frame(4'b1011, 0);
        send_frame(4'b0110, 0);
        idle(3);
        out_ready = 1'b1;
        idle(3);

        pulse_reset();
        out_ready = 1'b0;
        send_frame(4'b1011, 0);
        idle(2);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
`ifdef SIPO_DESER_PARITY_CHECK_EN
        send(1'b0, 1'b0);
        out_ready = 1'b1;
        send(1'b0, 1'b0);
`else
        out_ready = 1'b1;
        send(1'b0, 1'b0);
`endif
        idle(3);

        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
`ifdef SIPO_DESER_PARITY_CHECK_EN
        send(1'b0, 1'b0);
`endif
        idle(3);

        out_ready = 1'b0;
        send_frame(4'b1100, 0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        pulse_reset();
        out_ready = 1'b1;
        send_frame(4'b0101, 0);
        idle(3);

`ifdef SIPO_DESER_PARITY_CHECK_EN
        send_frame(4'b1011, 0);
        idle(2);
        send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        idle(3);
`endif

        repeat (3000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                serial_in   = 1'($urandom);
                bit_valid   = ($urandom_range(0, 3) != 0);
                frame_start = ($urandom_range(0, 19) == 0);
                @(posedge clk); #1;
            end
        end

        out_ready = 1'b1;
        idle(5);
        done = 1'b1;
    end

endmodule
